// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions.
package lc3b_types;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FLUSH,
    RD_DRAIN,
    RD_LOAD
  } redirect_state_t;

endpackage

// File: rtl/register.sv
// Generic load-enabled register with asynchronous active-low clear.
module register #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] in,
  output logic [width-1:0] out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out <= '0;
    else if (load)
      out <= in;
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Writeback-driven redirect sequencer: flush younger stages, drain any
// in-flight I-fetch, then load the PC with the latched target.
module redirect_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned FLUSH_STAGES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_valid,
  input  logic                    wb_squash,
  input  logic [15:0]             wb_target,
  input  logic                    pipe_stall,
  input  logic                    imem_pending,
  input  logic                    imem_resp,
  output logic [FLUSH_STAGES-1:0] flush_vec,
  output logic                    fetch_hold,
  output logic                    discard_resp,
  output logic                    pc_load,
  output logic                    pc_sel,
  output logic [15:0]             redirect_pc,
  output logic                    busy,
  output logic [15:0]             redirect_count
);

  redirect_state_t state;
  logic [15:0]     count_q;
  logic            accept;

  // Requests outside RD_IDLE come from already-squashed younger work.
  assign accept = (state == RD_IDLE) & wb_valid & wb_squash & ~pipe_stall;

  register #(.width(16)) target_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .in    (wb_target),
    .out   (redirect_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RD_IDLE;
      count_q <= '0;
    end else begin
      if (accept)
        count_q <= count_q + 16'd1;
      case (state)
        RD_IDLE:  if (accept) state <= RD_FLUSH;
        RD_FLUSH: state <= (imem_resp | ~imem_pending) ? RD_LOAD : RD_DRAIN;
        RD_DRAIN: if (imem_resp) state <= RD_LOAD;
        RD_LOAD:  state <= RD_IDLE;
        default:  state <= RD_IDLE;
      endcase
    end
  end

  assign redirect_count = count_q;

  always_comb begin
    flush_vec    = '0;
    fetch_hold   = 1'b0;
    discard_resp = 1'b0;
    pc_load      = 1'b0;
    pc_sel       = 1'b0;
    busy         = (state != RD_IDLE);
    case (state)
      RD_FLUSH: begin
        flush_vec    = '1;
        fetch_hold   = 1'b1;
        discard_resp = imem_resp;
      end
      RD_DRAIN: begin
        fetch_hold   = 1'b1;
        discard_resp = imem_resp;
      end
      RD_LOAD: begin
        pc_load = 1'b1;
        pc_sel  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Sequences every control-flow redirect resolved in writeback: taken branch, JMP/RET, JSR/JSRR, TRAP. It latches the redirect target when writeback raises its squash, flushes the younger pipeline stages, and drains or discards any instruction-fetch response already in flight. It then loads the PC with the target in a single cycle. It sits between the writeback stage and the fetch-stage PC mux and holds fetch off while a redirect is in progress.

## Interface
- FLUSH_STAGES, default 4: width of `flush_vec`, one bit per stage younger than writeback (bit 0 = fetch).
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  writeback holds a valid instruction this cycle.
- wb_squash  in  1  writeback's `squash_instruction` (branch taken or JMP/JSR/TRAP).
- wb_target  in  16  redirect PC computed by writeback.
- pipe_stall  in  1  pipeline frozen (memory busy); no redirect accepted while high.
- imem_pending  in  1  fetch has an I-memory read issued with no response yet.
- imem_resp  in  1  I-memory response valid this cycle.
- flush_vec  out  FLUSH_STAGES  invalidate the corresponding stage register at the next edge.
- fetch_hold  out  1  fetch must not issue a new I-memory read.
- discard_resp  out  1  fetch must drop the I-memory response arriving this cycle.
- pc_load  out  1  load the PC this cycle.
- pc_sel  out  1  PC mux select: 1 = `redirect_pc`, 0 = PC+2.
- redirect_pc  out  16  latched redirect target.
- busy  out  1  state is not RD_IDLE.
- redirect_count  out  16  number of accepted redirects; wraps from 0xFFFF to 0x0000.

## Operation
- Acceptance condition: `wb_valid & wb_squash & ~pipe_stall` while in RD_IDLE.
  - On acceptance, `redirect_pc` latches `wb_target` and `redirect_count` increments by 1 (mod 2^16).
- Requests arriving in any state other than RD_IDLE are ignored: no latch, no count.
  - They can only come from squashed younger instructions.
- RD_IDLE: all outputs 0 except `redirect_pc` and `redirect_count`, which hold their values. Acceptance moves to RD_FLUSH.
- RD_FLUSH (exactly 1 cycle):
  - Outputs: `flush_vec` all ones, `fetch_hold`=1, `discard_resp`=`imem_resp`.
  - Exit: if `imem_resp | ~imem_pending`, go to RD_LOAD; otherwise go to RD_DRAIN.
- RD_DRAIN:
  - Outputs: `fetch_hold`=1, `discard_resp`=`imem_resp`, `flush_vec`=0.
  - Exit: stay until `imem_resp`, then go to RD_LOAD.
  - `pipe_stall` does not affect draining.
- RD_LOAD (exactly 1 cycle):
  - Outputs: `pc_load`=1, `pc_sel`=1, `fetch_hold`=0.
  - Exit: to RD_IDLE.
- `pc_sel` and `pc_load` are 0 in every state except RD_LOAD; the fetch stage's own PC+2 path is outside this block.
- `busy` = (state != RD_IDLE).
- Reset (asynchronous, at any time including mid-sequence):
  - State goes to RD_IDLE.
  - `redirect_pc`=0x0000, `redirect_count`=0x0000.
  - All other outputs 0.
  - An in-progress redirect is abandoned; there is no pending discard obligation after reset.

## Timing
- State, `redirect_pc` and `redirect_count` are registered.
- All outputs are decoded from state only (Moore), except `discard_resp`, which is state AND `imem_resp`.
- Request sampled in cycle T:
  - With no fetch in flight: RD_FLUSH in T+1, RD_LOAD (`pc_load`) in T+2, RD_IDLE in T+3. A new request can be accepted in T+3.
  - With a fetch in flight whose response arrives in cycle T+k (k≥2): RD_DRAIN covers T+2..T+k, RD_LOAD in T+k+1.
  - If the response arrives in T+1: it is discarded in RD_FLUSH and RD_LOAD follows in T+2.
- Request with `pipe_stall`=1 in cycle T: not accepted. Writeback holds it; it is accepted in the first cycle in which `pipe_stall`=0.
- Minimum spacing between two accepted redirects: 3 cycles.

## Structure
- Add to the shared `lc3b_types` package: enum `redirect_state_t {RD_IDLE, RD_FLUSH, RD_DRAIN, RD_LOAD}`.
- The target latch uses the existing `register` module with `.width(16)`, loaded on acceptance.
- No other sub-module. The FSM, output decode and counter live in `redirect_ctrl`.

## Test plan
- Reset, then BR taken with `wb_target`=0x3010 and `imem_pending`=0:
  - Required: `flush_vec`=4'b1111 for one cycle, then `pc_load`=1 with `redirect_pc`=0x3010, then idle.
  - `redirect_count`=1.
- JSR with `imem_pending`=1 and response 3 cycles later:
  - Required: `fetch_hold` held through RD_DRAIN, `discard_resp`=1 exactly in the response cycle, `pc_load` on the following cycle.
- Request with `pipe_stall`=1 for 2 cycles, then 0:
  - Required: no flush while stalled; RD_FLUSH one cycle after the stall drops.
  - Target is the value present at acceptance.
- Second `wb_squash` (target 0x4000) asserted during RD_FLUSH and RD_LOAD of a redirect to 0x2000:
  - Required: ignored; `redirect_pc` stays 0x2000 and `redirect_count` increments by 1 only.
- `rst_n` asserted low during RD_DRAIN:
  - Required: outputs 0 immediately (asynchronous), state RD_IDLE, `redirect_pc`=0x0000, `redirect_count`=0x0000.
  - The next request after release sequences normally.
- Preload `redirect_count`=0xFFFF via 65535 redirects (or force), then one more redirect:
  - Required: `redirect_count` wraps to 0x0000.
